// File: rtl/led_pwm_pio.sv
// ----------------------------------------------------------------------------
// led_pwm_pio
//   Avalon-MM slave register block driving WIDTH LED lines. Each channel is
//   either static (DATA bit) or PWM-dimmed against its own DUTY value, all
//   sharing one prescaled PWM timebase.
//
//   Optional feature: define LED_PWM_PIO_BLINK_EN to add the BLINK register
//   and a blink phase that toggles on every PWM period wrap, gating the
//   selected channels off during the odd phase.
//
// Register map (word address):
//   0       DATA[WIDTH-1:0]
//   1       MODE[WIDTH-1:0]     0 = static, 1 = PWM
//   2       PRESCALE[PRESC_BITS-1:0]  (write also restarts the timebase)
//   3       BLINK[WIDTH-1:0]    (only with LED_PWM_PIO_BLINK_EN, else reads 0)
//   4+i     DUTY_i[PWM_BITS-1:0]
//
// Ports:
//   clk_clk        system clock
//   reset_reset_n  synchronous active-low reset
//   avs_address    word address
//   avs_read       read strobe, readdata valid one cycle later
//   avs_write      write strobe
//   avs_writedata  write data
//   avs_readdata   registered read data, held until the next read
//   leds_export    registered LED drive, active high
// ----------------------------------------------------------------------------
module led_pwm_pio #(
    parameter int WIDTH      = 8,
    parameter int PWM_BITS   = 8,
    parameter int PRESC_BITS = 16,
    parameter int ADDR_BITS  = 5
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [ADDR_BITS-1:0] avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic [WIDTH-1:0]     leds_export
);

    localparam logic [ADDR_BITS-1:0] A_DATA  = ADDR_BITS'(0);
    localparam logic [ADDR_BITS-1:0] A_MODE  = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] A_PRESC = ADDR_BITS'(2);
    localparam logic [ADDR_BITS-1:0] A_BLINK = ADDR_BITS'(3);

    logic [WIDTH-1:0]      data_r;
    logic [WIDTH-1:0]      mode_r;
    logic [PRESC_BITS-1:0] presc_r;
    logic [PWM_BITS-1:0]   duty_r [WIDTH];

    logic [PRESC_BITS-1:0] presc_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic                  tick;
    logic                  presc_wr;

    logic [31:0]           rd_mux;
    logic [WIDTH-1:0]      led_level;
    logic [WIDTH-1:0]      blink_gate;
    logic [WIDTH-1:0]      leds_p1;

`ifdef LED_PWM_PIO_BLINK_EN
    logic [WIDTH-1:0]      blink_r;
    logic                  blink_phase;
`endif

    // Upper write-data bits beyond the widest register are intentionally dropped.
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata;

    assign presc_wr = avs_write && (avs_address == A_PRESC);
    assign tick     = (presc_cnt == presc_r);

    // ---- Register file -----------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            data_r  <= '0;
            mode_r  <= '0;
            presc_r <= '0;
            for (int i = 0; i < WIDTH; i++) duty_r[i] <= '0;
`ifdef LED_PWM_PIO_BLINK_EN
            blink_r <= '0;
`endif
        end else if (avs_write) begin
            if (avs_address == A_DATA)  data_r  <= avs_writedata[WIDTH-1:0];
            if (avs_address == A_MODE)  mode_r  <= avs_writedata[WIDTH-1:0];
            if (avs_address == A_PRESC) presc_r <= avs_writedata[PRESC_BITS-1:0];
`ifdef LED_PWM_PIO_BLINK_EN
            if (avs_address == A_BLINK) blink_r <= avs_writedata[WIDTH-1:0];
`endif
            for (int i = 0; i < WIDTH; i++) begin
                if (avs_address == ADDR_BITS'(4 + i))
                    duty_r[i] <= avs_writedata[PWM_BITS-1:0];
            end
        end
    end

    // Read mux works on pre-write register values, so a same-cycle
    // read/write of one address returns the old contents.
    always_comb begin
        rd_mux = '0;
        if (avs_address == A_DATA)  rd_mux[WIDTH-1:0]      = data_r;
        if (avs_address == A_MODE)  rd_mux[WIDTH-1:0]      = mode_r;
        if (avs_address == A_PRESC) rd_mux[PRESC_BITS-1:0] = presc_r;
`ifdef LED_PWM_PIO_BLINK_EN
        if (avs_address == A_BLINK) rd_mux[WIDTH-1:0]      = blink_r;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            if (avs_address == ADDR_BITS'(4 + i))
                rd_mux[PWM_BITS-1:0] = duty_r[i];
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n)
            avs_readdata <= '0;
        else if (avs_read)
            avs_readdata <= rd_mux;
    end

    // ---- Timebase: prescaler -> PWM counter -> blink phase ------------------
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n || presc_wr) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
`ifdef LED_PWM_PIO_BLINK_EN
            blink_phase <= 1'b0;
`endif
        end else if (tick) begin
            presc_cnt <= '0;
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
`ifdef LED_PWM_PIO_BLINK_EN
            if (pwm_cnt == '1) blink_phase <= ~blink_phase;
`endif
        end else begin
            presc_cnt <= presc_cnt + PRESC_BITS'(1);
        end
    end

    // ---- Channel level and output register (stage p1) ----------------------
    always_comb begin
        for (int i = 0; i < WIDTH; i++)
            led_level[i] = mode_r[i] ? (pwm_cnt < duty_r[i]) : data_r[i];
    end

`ifdef LED_PWM_PIO_BLINK_EN
    assign blink_gate = blink_r & {WIDTH{blink_phase}};
`else
    assign blink_gate = '0;
`endif

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n)
            leds_p1 <= '0;
        else
            leds_p1 <= led_level & ~blink_gate;
    end

    assign leds_export = leds_p1;

endmodule

// File: tb/tb_led_pwm_pio.sv
// ----------------------------------------------------------------------------
// tb_led_pwm_pio
//   Directed bench for led_pwm_pio with WIDTH=8, PWM_BITS=4. Inputs change on
//   the falling edge, outputs are sampled on the falling edge. PWM waveforms
//   are captured one sample per cycle, starting the cycle after a PRESCALE
//   write restarts the timebase, and compared to hand-derived bit patterns.
// ----------------------------------------------------------------------------
module tb_led_pwm_pio;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [4:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [7:0]  leds_export;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [31:0] rv;
    logic [63:0] wave;

    always #5 clk_clk = ~clk_clk;

    led_pwm_pio #(
        .WIDTH      (8),
        .PWM_BITS   (4),
        .PRESC_BITS (16),
        .ADDR_BITS  (5)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .leds_export   (leds_export)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk_clk);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk_clk);
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk_clk);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk_clk);
        avs_read    = 1'b0;
        d = avs_readdata;
    endtask

    // Bit k-1 of v holds leds_export[0] at the k-th falling edge from now.
    task automatic sample(input int n, output logic [63:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_clk);
            v[i] = leds_export[0];
        end
    endtask

    initial begin
        reset_reset_n = 1'b0;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;

        // Reset held 3 cycles with a DATA write pending: write must be ignored.
        @(negedge clk_clk);
        avs_address   = 5'd0;
        avs_writedata = 32'hFF;
        avs_write     = 1'b1;
        repeat (3) @(negedge clk_clk);
        chk("reset_leds", {56'b0, leds_export}, 64'h0);
        chk("reset_readdata", {32'b0, avs_readdata}, 64'h0);
        avs_write     = 1'b0;
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        chk("reset_leds_after", {56'b0, leds_export}, 64'h0);
        rd(5'd0, rv); chk("reset_data", {32'b0, rv}, 64'h0);
        rd(5'd1, rv); chk("reset_mode", {32'b0, rv}, 64'h0);
        rd(5'd2, rv); chk("reset_presc", {32'b0, rv}, 64'h0);
        rd(5'd3, rv); chk("reset_blink", {32'b0, rv}, 64'h0);
        rd(5'd4, rv); chk("reset_duty0", {32'b0, rv}, 64'h0);

        // Static output: one edge for the register, one for the LED flop.
        wr(5'd0, 32'hA5);
        chk("static_latency", {56'b0, leds_export}, 64'h0);
        @(negedge clk_clk);
        chk("static_leds", {56'b0, leds_export}, 64'hA5);
        rd(5'd0, rv); chk("static_read", {32'b0, rv}, 64'hA5);

        // Same-cycle read and write of DATA returns the old value.
        @(negedge clk_clk);
        avs_address   = 5'd0;
        avs_writedata = 32'h3C;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        @(negedge clk_clk);
        avs_write     = 1'b0;
        avs_read      = 1'b0;
        chk("rw_same_old", {32'b0, avs_readdata}, 64'hA5);
        rd(5'd0, rv); chk("rw_same_new", {32'b0, rv}, 64'h3C);
        rd(5'd31, rv); chk("unmapped_read", {32'b0, rv}, 64'h0);
        wr(5'd31, 32'hFFFF_FFFF);
        rd(5'd0, rv); chk("unmapped_wr_data", {32'b0, rv}, 64'h3C);
        rd(5'd1, rv); chk("unmapped_wr_mode", {32'b0, rv}, 64'h0);
        rd(5'd2, rv); chk("unmapped_wr_presc", {32'b0, rv}, 64'h0);
        rd(5'd3, rv); chk("unmapped_wr_blink", {32'b0, rv}, 64'h0);
        rd(5'd11, rv); chk("unmapped_wr_duty7", {32'b0, rv}, 64'h0);
        wr(5'd0, 32'hFFFF_FF3C);
        rd(5'd0, rv); chk("upper_bits_dropped", {32'b0, rv}, 64'h3C);

        // PWM on channel 0, PRESCALE=0: 4 of every 16 cycles high.
        wr(5'd4, 32'd4);
        wr(5'd1, 32'h01);
        rd(5'd4, rv); chk("duty0_read", {32'b0, rv}, 64'h4);
        wr(5'd2, 32'd0);
        sample(32, wave);
        chk("pwm_duty4", wave, 64'h0000_0000_000F_000F);
        chk("pwm_static_bits", {56'b0, leds_export & 8'hFE}, 64'h3C);

        wr(5'd4, 32'd0);
        wr(5'd2, 32'd0);
        sample(32, wave);
        chk("pwm_duty0", wave, 64'h0);

        wr(5'd4, 32'd15);
        wr(5'd2, 32'd0);
        sample(32, wave);
        chk("pwm_duty15", wave, 64'h0000_0000_7FFF_7FFF);

        // PRESCALE=1 doubles every PWM step: 8 high then 24 low.
        wr(5'd4, 32'd4);
        wr(5'd2, 32'd1);
        rd(5'd2, rv); chk("presc_read", {32'b0, rv}, 64'h1);
        wr(5'd2, 32'd1);
        sample(64, wave);
        chk("pwm_presc1", wave, 64'h0000_00FF_0000_00FF);

        // Blink on a static channel.
        wr(5'd1, 32'h00);
        wr(5'd0, 32'h01);
        wr(5'd3, 32'h01);
        rd(5'd3, rv);
`ifdef LED_PWM_PIO_BLINK_EN
        chk("blink_read", {32'b0, rv}, 64'h1);
        wr(5'd2, 32'd0);
        sample(64, wave);
        chk("blink_wave", wave, 64'h0000_FFFF_0000_FFFF);
`else
        chk("blink_read", {32'b0, rv}, 64'h0);
        wr(5'd2, 32'd0);
        sample(64, wave);
        chk("blink_wave", wave, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

        // Reset in the middle of a PWM high phase.
        wr(5'd3, 32'h00);
        wr(5'd1, 32'h01);
        wr(5'd4, 32'd8);
        wr(5'd2, 32'd0);
        sample(4, wave);
        chk("midpwm_high", wave, 64'hF);
        reset_reset_n = 1'b0;
        @(negedge clk_clk);
        chk("midpwm_reset_leds", {56'b0, leds_export}, 64'h0);
        reset_reset_n = 1'b1;
        rd(5'd4, rv); chk("midpwm_reset_duty", {32'b0, rv}, 64'h0);
        rd(5'd1, rv); chk("midpwm_reset_mode", {32'b0, rv}, 64'h0);
        wr(5'd1, 32'h01);
        wr(5'd4, 32'd8);
        wr(5'd2, 32'd0);
        sample(32, wave);
        chk("midpwm_restart", wave, 64'h0000_0000_00FF_00FF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
